// File: rtl/seq_divider_param.sv
// Multi-cycle restoring integer divider with configurable width, per-operation
// signed/unsigned mode, divide-by-zero flag and a busy/ready handshake.
module seq_divider_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [2*WIDTH-1:0]   work_r;
    logic [WIDTH-1:0]     divisor_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 neg_q_r;
    logic                 neg_rem_r;
    logic                 zero_r;
    logic [WIDTH-1:0]     quotient_r;
    logic [WIDTH-1:0]     remainder_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 div_zero_r;

    logic                 accept_s;
    logic                 last_iter_s;
    logic                 zero_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH:0]       partial_s;
    logic [WIDTH:0]       diff_s;
    logic [2*WIDTH-1:0]   work_step_s;

    // Two's-complement negation when requested; the minimum negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            cond_negate = ~v + WIDTH'(1'b1);
        end else begin
            cond_negate = v;
        end
    endfunction

    assign accept_s    = run & ~busy_r & ((state_r == IDLE) | (state_r == DONE));
    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
    assign zero_s      = (Divisor == {WIDTH{1'b0}});
    assign a_neg_s     = signed_mode & Dividend[WIDTH-1];
    assign b_neg_s     = signed_mode & Divisor[WIDTH-1];

    // One restoring step; the partial remainder keeps the bit shifted out of the top.
    always_comb begin
        partial_s   = work_r[2*WIDTH-1:WIDTH-1];
        diff_s      = partial_s - {1'b0, divisor_r};
        work_step_s = {2*WIDTH{1'b0}};
        if (!diff_s[WIDTH]) begin
            work_step_s = {diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
        end else begin
            work_step_s = {partial_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero divisor skips the iterations entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_next_s = zero_s ? FIXUP : DIVIDE;
                end else begin
                    state_next_s = state_r;
                end
            end
            DIVIDE: begin
                if (last_iter_s) begin
                    state_next_s = FIXUP;
                end else begin
                    state_next_s = DIVIDE;
                end
            end
            FIXUP:   state_next_s = DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath, result registers and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_r      <= {2*WIDTH{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            zero_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            div_zero_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            div_zero_r <= 1'b0;
            zero_r     <= zero_s;
            divisor_r  <= cond_negate(Divisor, b_neg_s);
            if (zero_s) begin
                work_r    <= {Dividend, {WIDTH{1'b1}}};
                neg_q_r   <= 1'b0;
                neg_rem_r <= 1'b0;
            end else begin
                work_r    <= {{WIDTH{1'b0}}, cond_negate(Dividend, a_neg_s)};
                neg_q_r   <= a_neg_s ^ b_neg_s;
                neg_rem_r <= a_neg_s;
            end
        end else if (state_r == DIVIDE) begin
            work_r <= work_step_s;
            cnt_r  <= cnt_r + CNT_W'(1'b1);
        end else if (state_r == FIXUP) begin
            quotient_r  <= cond_negate(work_r[WIDTH-1:0], neg_q_r);
            remainder_r <= cond_negate(work_r[2*WIDTH-1:WIDTH], neg_rem_r);
            div_zero_r  <= zero_r;
        end else if (state_r == DONE) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end
    end

    assign Quotient  = quotient_r;
    assign Remainder = remainder_r;
    assign ready     = ready_r;
    assign busy      = busy_r;
    assign div_zero  = div_zero_r;

endmodule
